fetch_unit: RTL and testbench

//  Instruction-fetch stage; feeds the IF/ID register consumed by decode/control.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem,
// and feeds IF/ID through a one-entry skid buffer on stall.
module fetch_unit #(
  parameter int               PC_W     = 8,
  parameter int               INSTR_W  = 32,
  parameter int               PC_STEP  = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc4,
  output logic               ifid_valid
);

  typedef enum logic {
    RUN  = 1'b0,
    SKID = 1'b1
  } state_t;

  state_t              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     req_pc_q;
  logic                req_valid_q;
  logic [INSTR_W-1:0]  skid_instr_q;
  logic [PC_W-1:0]     skid_pc4_q;
  logic [INSTR_W-1:0]  ifid_instr_q;
  logic [PC_W-1:0]     ifid_pc4_q;
  logic                ifid_valid_q;

  logic [PC_W-1:0]     pc_d;
  logic [PC_W-1:0]     req_pc4_d;
  logic [PC_W-1:0]     tgt_d;
  logic                unused_tgt;

  assign pc_d       = pc_q + PC_W'(PC_STEP);
  assign req_pc4_d  = req_pc_q + PC_W'(PC_STEP);
  assign tgt_d      = {branch_target_i[PC_W-1:2], 2'b00};
  assign unused_tgt = ^branch_target_i[1:0];

  assign imem_addr  = pc_q;
  assign imem_rd_en = !rst && !stall_i && !branch_taken_i &&
                      (state_q == RUN || state_q == SKID);

  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (branch_taken_i) begin
      // The response to last cycle's request is wrong-path; drop it.
      state_q      <= RUN;
      pc_q         <= tgt_d;
      req_valid_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (!stall_i) begin
        pc_q         <= pc_d;
        req_pc_q     <= pc_q;
        req_valid_q  <= 1'b1;
        ifid_valid_q <= req_valid_q;
        if (req_valid_q) begin
          ifid_instr_q <= imem_rdata;
          ifid_pc4_q   <= req_pc4_d;
        end
      end else if (req_valid_q) begin
        // Response lands while decode is stalled; park it.
        skid_instr_q <= imem_rdata;
        skid_pc4_q   <= req_pc4_d;
        req_valid_q  <= 1'b0;
        state_q      <= SKID;
      end
    end else if (!stall_i) begin
      ifid_instr_q <= skid_instr_q;
      ifid_pc4_q   <= skid_pc4_q;
      ifid_valid_q <= 1'b1;
      pc_q         <= pc_d;
      req_pc_q     <= pc_q;
      req_valid_q  <= 1'b1;
      state_q      <= RUN;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall/skid, branch,
// branch-in-skid, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [7:0]  tgt;
  logic [7:0]  addr;
  logic        rd_en;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [7:0]  pc4;
  logic        valid;

  logic        rst2, stall2, br2;
  logic [7:0]  tgt2;
  logic [7:0]  addr2;
  logic        rd_en2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [7:0]  pc42;
  logic        valid2;

  int vectors = 0;
  int miscompares = 0;
  int exp_w;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .INSTR_W(32), .PC_STEP(4), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(tgt), .imem_addr(addr), .imem_rd_en(rd_en),
    .imem_rdata(rdata), .ifid_instr(instr), .ifid_pc4(pc4),
    .ifid_valid(valid)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(32), .PC_STEP(4), .RESET_PC(8'hF8)) u_dut_f8 (
    .clk(clk), .rst(rst2), .stall_i(stall2), .branch_taken_i(br2),
    .branch_target_i(tgt2), .imem_addr(addr2), .imem_rd_en(rd_en2),
    .imem_rdata(rdata2), .ifid_instr(instr2), .ifid_pc4(pc42),
    .ifid_valid(valid2)
  );

  // Word at byte address a is 0x1000_0000 + a/4
  always @(posedge clk) begin
    if (rd_en)  rdata  <= 32'h1000_0000 | {24'h0, 2'b00, addr[7:2]};
    if (rd_en2) rdata2 <= 32'h1000_0000 | {24'h0, 2'b00, addr2[7:2]};
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({valid, pc4, instr} !== 41'h0) begin
      $display("FAIL reset_ifid got v=%b pc4=%h instr=%h exp 0", valid, pc4, instr);
      miscompares++;
    end
    vectors++;
    if ({rd_en, addr} !== 9'h0) begin
      $display("FAIL reset_imem got en=%b addr=%h exp en=0 addr=00", rd_en, addr);
      miscompares++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({rd_en, addr} !== {1'b1, 8'h00}) begin
      $display("FAIL release_imem got en=%b addr=%h exp en=1 addr=00", rd_en, addr);
      miscompares++;
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    vectors++;
    if ({valid, addr} !== {1'b0, 8'h04}) begin
      $display("FAIL t1_first got v=%b addr=%h exp v=0 addr=04", valid, addr);
      miscompares++;
    end
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (addr !== 8'(4 * k)) begin
        $display("FAIL t1_addr k=%0d got %h exp %h", k, addr, 8'(4 * k));
        miscompares++;
      end
      vectors++;
      if ({valid, pc4, instr} !== {1'b1, 8'(4 * k - 4), 32'h1000_0000 + 32'(k - 2)}) begin
        $display("FAIL t1_ifid k=%0d got v=%b pc4=%h instr=%h exp pc4=%h instr=%h",
                 k, valid, pc4, instr, 8'(4 * k - 4), 32'h1000_0000 + 32'(k - 2));
        miscompares++;
      end
    end
    exp_w = 5;
  endtask

  task automatic test_stall();
    int w;
    w = exp_w;
    stall = 1'b1;
    #1;
    vectors++;
    if (rd_en !== 1'b0) begin
      $display("FAIL t2_rden_start got %b exp 0", rd_en);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({valid, pc4, instr, rd_en} !== {1'b1, 8'(4 * w + 4), 32'h1000_0000 + 32'(w), 1'b0}) begin
        $display("FAIL t2_hold i=%0d got v=%b pc4=%h instr=%h en=%b exp word %0d en=0",
                 i, valid, pc4, instr, rd_en, w);
        miscompares++;
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w++;
      vectors++;
      if ({valid, pc4, instr} !== {1'b1, 8'(4 * w + 4), 32'h1000_0000 + 32'(w)}) begin
        $display("FAIL t2_resume i=%0d got v=%b pc4=%h instr=%h exp pc4=%h instr=%h",
                 i, valid, pc4, instr, 8'(4 * w + 4), 32'h1000_0000 + 32'(w));
        miscompares++;
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) @(negedge clk);
    vectors++;
    if (addr !== 8'h10) begin
      $display("FAIL t3_pre_addr got %h exp 10", addr);
      miscompares++;
    end
    br = 1'b1;
    tgt = 8'h40;
    #1;
    vectors++;
    if (rd_en !== 1'b0) begin
      $display("FAIL t3_rden got %b exp 0", rd_en);
      miscompares++;
    end
    @(negedge clk);
    br = 1'b0;
    vectors++;
    if ({valid, addr} !== {1'b0, 8'h40}) begin
      $display("FAIL t3_redirect got v=%b addr=%h exp v=0 addr=40", valid, addr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0) begin
      $display("FAIL t3_bubble2 got v=%b exp 0", valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, pc4, instr} !== {1'b1, 8'h44, 32'h1000_0010}) begin
      $display("FAIL t3_target got v=%b pc4=%h instr=%h exp pc4=44 instr=10000010",
               valid, pc4, instr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, pc4, instr} !== {1'b1, 8'h48, 32'h1000_0011}) begin
      $display("FAIL t3_next got v=%b pc4=%h instr=%h exp pc4=48 instr=10000011",
               valid, pc4, instr);
      miscompares++;
    end
  endtask

  task automatic test_branch_in_skid();
    do_reset();
    repeat (4) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    br = 1'b1;
    tgt = 8'h83;
    #1;
    vectors++;
    if (rd_en !== 1'b0) begin
      $display("FAIL t4_rden got %b exp 0", rd_en);
      miscompares++;
    end
    @(negedge clk);
    br = 1'b0;
    vectors++;
    if ({valid, addr} !== {1'b0, 8'h80}) begin
      $display("FAIL t4_redirect got v=%b addr=%h exp v=0 addr=80", valid, addr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, addr, rd_en} !== {1'b0, 8'h80, 1'b0}) begin
      $display("FAIL t4_stalled got v=%b addr=%h en=%b exp v=0 addr=80 en=0",
               valid, addr, rd_en);
      miscompares++;
    end
    stall = 1'b0;
    #1;
    vectors++;
    if ({rd_en, addr} !== {1'b1, 8'h80}) begin
      $display("FAIL t4_issue got en=%b addr=%h exp en=1 addr=80", rd_en, addr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, addr} !== {1'b0, 8'h84}) begin
      $display("FAIL t4_bubble got v=%b addr=%h exp v=0 addr=84", valid, addr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, pc4, instr} !== {1'b1, 8'h84, 32'h1000_0020}) begin
      $display("FAIL t4_target got v=%b pc4=%h instr=%h exp pc4=84 instr=10000020",
               valid, pc4, instr);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, pc4, instr} !== {1'b1, 8'h88, 32'h1000_0021}) begin
      $display("FAIL t4_next got v=%b pc4=%h instr=%h exp pc4=88 instr=10000021",
               valid, pc4, instr);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [5];
    logic [7:0]  exp_p [5];
    logic [31:0] exp_i [5];
    exp_a = '{8'hF8, 8'hFC, 8'h00, 8'h04, 8'h08};
    exp_p = '{8'h00, 8'h00, 8'hFC, 8'h00, 8'h04};
    exp_i = '{32'h0, 32'h0, 32'h1000_003E, 32'h1000_003F, 32'h1000_0000};
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (addr2 !== exp_a[k]) begin
        $display("FAIL t5_addr k=%0d got %h exp %h", k, addr2, exp_a[k]);
        miscompares++;
      end
      vectors++;
      if ({valid2, pc42, instr2} !== {k >= 2, exp_p[k], exp_i[k]}) begin
        $display("FAIL t5_ifid k=%0d got v=%b pc4=%h instr=%h exp v=%b pc4=%h instr=%h",
                 k, valid2, pc42, instr2, k >= 2, exp_p[k], exp_i[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({valid, pc4, instr, rd_en, addr} !== 50'h0) begin
      $display("FAIL t6_clear got v=%b pc4=%h instr=%h en=%b addr=%h exp all 0",
               valid, pc4, instr, rd_en, addr);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({rd_en, addr, valid} !== {1'b1, 8'h00, 1'b0}) begin
      $display("FAIL t6_release got en=%b addr=%h v=%b exp en=1 addr=00 v=0",
               rd_en, addr, valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({valid, addr} !== {1'b0, 8'h04}) begin
      $display("FAIL t6_first got v=%b addr=%h exp v=0 addr=04", valid, addr);
      miscompares++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({valid, pc4, instr} !== {1'b1, 8'(4 * k + 4), 32'h1000_0000 + 32'(k)}) begin
        $display("FAIL t6_refetch k=%0d got v=%b pc4=%h instr=%h exp pc4=%h instr=%h",
                 k, valid, pc4, instr, 8'(4 * k + 4), 32'h1000_0000 + 32'(k));
        miscompares++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 8'h00;
    rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; tgt2 = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_in_skid();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
